pipe_stage_if: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS core. It sits directly upstream of the ID stage and is the block that ID's pc_plus_4 and instruction inputs come from.
- Owns the PC register, next-PC selection and the IF/ID pipeline register.
- Consumes ID's wpcir (active-low stall), pcsource, branch_target and jump_target, plus the forwarded rs value for jr.
- Keeps delayed-branch semantics: no flush; the instruction after a branch/jump always executes.
- Provides sticky misalignment detection and fetch/stall performance counters.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/mux4x32.sv | 25 ++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_stage_if.sv | 87 ++++++++
 tb/tb_pipe_stage_if.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stages: next-PC source encodings and the NOP word.
// Also holds the word-alignment helper used by the fetch stage.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mux4x32.sv
// Four-way 32-bit multiplexer, used for next-PC selection.
// Select encodings follow the pcsource values from the ID stage.
module mux4x32
    import pipe_pkg::*;
(
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    always_comb begin
        y = a0;
        case (s)
            PCSRC_SEQ: y = a0;
            PCSRC_BR:  y = a1;
            PCSRC_JR:  y = a2;
            PCSRC_J:   y = a3;
            default:   y = a0;
        endcase
    end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping so long runs never read back as small values.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_if.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register,
// sticky misalignment flag and fetch/stall counters. Delayed-branch: nothing is flushed.
module pipe_stage_if
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wpcir,
    input  logic [1:0]       pcsource,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      reg_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ID_pc_plus_4,
    output logic [31:0]      inst_stored,
    output logic [31:0]      IF_pc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_stall
);

    logic [31:0] r_pc;
    logic [31:0] r_idPcPlus4;
    logic [31:0] r_inst;
    logic        r_misalignErr;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_npc;
    logic        w_misalign;

    assign w_pcPlus4 = r_pc + 32'd4;

    mux4x32 uNpcMux (
        .a0 (w_pcPlus4),
        .a1 (branch_target),
        .a2 (reg_target),
        .a3 (jump_target),
        .s  (pcsource),
        .y  (w_npc)
    );

    // Sequential fetches are always aligned, so only redirects can raise the flag.
    assign w_misalign = wpcir && (pcsource != PCSRC_SEQ) && (w_npc[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_idPcPlus4   <= RESET_PC;
            r_inst        <= NOP_INST;
            r_misalignErr <= 1'b0;
        end else begin
            if (wpcir) begin
                r_pc        <= wordAlign(w_npc);
                r_idPcPlus4 <= w_pcPlus4;
                r_inst      <= imem_rdata;
            end
            if (w_misalign) begin
                r_misalignErr <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) uFetchCnt (
        .clock (clock),
        .reset (reset),
        .inc   (wpcir),
        .count (cnt_fetch)
    );

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clock (clock),
        .reset (reset),
        .inc   (~wpcir),
        .count (cnt_stall)
    );

    assign imem_addr    = r_pc;
    assign IF_pc        = r_pc;
    assign ID_pc_plus_4 = r_idPcPlus4;
    assign inst_stored  = r_inst;
    assign misalign_err = r_misalignErr;

endmodule

// File: tb/tb_pipe_stage_if.sv
// Directed bench for pipe_stage_if: table of per-edge vectors plus hand-written
// sequences for counter saturation and PC wrap-around. ROM[i] = 32'h1000_0000 + i.
module tb_pipe_stage_if;

    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             wpcir;
    logic [1:0]       pcsource;
    logic [31:0]      branch_target;
    logic [31:0]      jump_target;
    logic [31:0]      reg_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      ID_pc_plus_4;
    logic [31:0]      inst_stored;
    logic [31:0]      IF_pc;
    logic             misalign_err;
    logic [CNT_W-1:0] cnt_fetch;
    logic [CNT_W-1:0] cnt_stall;

    int checkCount;
    int failCount;

    typedef struct {
        logic        rst;
        logic        wp;
        logic [1:0]  ps;
        logic [31:0] br;
        logic [31:0] jt;
        logic [31:0] rt;
        logic [31:0] expPc;
        logic [31:0] expPp4;
        logic [31:0] expInst;
        logic        expErr;
        logic [3:0]  expCf;
        logic [3:0]  expCs;
    } vec_t;

    vec_t vecs[18];

    pipe_stage_if #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .wpcir         (wpcir),
        .pcsource      (pcsource),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ID_pc_plus_4  (ID_pc_plus_4),
        .inst_stored   (inst_stored),
        .IF_pc         (IF_pc),
        .misalign_err  (misalign_err),
        .cnt_fetch     (cnt_fetch),
        .cnt_stall     (cnt_stall)
    );

    // Asynchronous ROM model: word index tagged with a fixed high pattern.
    assign imem_rdata = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic wp, input logic [1:0] ps,
                                input logic [31:0] br, input logic [31:0] jt, input logic [31:0] rt,
                                input logic [31:0] pc, input logic [31:0] pp4, input logic [31:0] inst,
                                input logic err, input logic [3:0] cf, input logic [3:0] cs);
        vec_t v;
        v.rst = rst; v.wp = wp; v.ps = ps; v.br = br; v.jt = jt; v.rt = rt;
        v.expPc = pc; v.expPp4 = pp4; v.expInst = inst; v.expErr = err;
        v.expCf = cf; v.expCs = cs;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic wp, input logic [1:0] ps,
                                 input logic [31:0] br, input logic [31:0] jt, input logic [31:0] rt);
        reset         = rst;
        wpcir         = wp;
        pcsource      = ps;
        branch_target = br;
        jump_target   = jt;
        reg_target    = rt;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        branch_target = '0; jump_target = '0; reg_target = '0;

        //           rst wp ps  br        jt        rt        pc        pp4       inst          err cf  cs
        vecs[0]  = mk(1, 1, 0, 0,        0,        0,        32'h0,    32'h0,    32'h0,        0,  0,  0);
        vecs[1]  = mk(1, 0, 3, 0,        32'h80,   0,        32'h0,    32'h0,    32'h0,        0,  0,  0);
        vecs[2]  = mk(0, 1, 0, 0,        0,        0,        32'h4,    32'h4,    32'h1000_0000, 0, 1,  0);
        vecs[3]  = mk(0, 1, 0, 0,        0,        0,        32'h8,    32'h8,    32'h1000_0001, 0, 2,  0);
        vecs[4]  = mk(0, 0, 0, 0,        0,        0,        32'h8,    32'h8,    32'h1000_0001, 0, 2,  1);
        vecs[5]  = mk(0, 0, 1, 32'h40,   0,        0,        32'h8,    32'h8,    32'h1000_0001, 0, 2,  2);
        vecs[6]  = mk(0, 0, 3, 0,        32'h80,   0,        32'h8,    32'h8,    32'h1000_0001, 0, 2,  3);
        vecs[7]  = mk(0, 1, 0, 0,        0,        0,        32'hC,    32'hC,    32'h1000_0002, 0, 3,  3);
        vecs[8]  = mk(0, 1, 1, 32'h40,   0,        0,        32'h40,   32'h10,   32'h1000_0003, 0, 4,  3);
        vecs[9]  = mk(0, 1, 0, 0,        0,        0,        32'h44,   32'h44,   32'h1000_0010, 0, 5,  3);
        vecs[10] = mk(0, 0, 3, 0,        32'h80,   0,        32'h44,   32'h44,   32'h1000_0010, 0, 5,  4);
        vecs[11] = mk(0, 1, 3, 0,        32'h80,   0,        32'h80,   32'h48,   32'h1000_0011, 0, 6,  4);
        vecs[12] = mk(0, 1, 2, 0,        0,        32'h106,  32'h104,  32'h84,   32'h1000_0020, 1, 7,  4);
        vecs[13] = mk(0, 1, 0, 0,        0,        0,        32'h108,  32'h108,  32'h1000_0041, 1, 8,  4);
        vecs[14] = mk(0, 1, 0, 0,        0,        0,        32'h10C,  32'h10C,  32'h1000_0042, 1, 9,  4);
        vecs[15] = mk(1, 0, 1, 32'h40,   0,        0,        32'h0,    32'h0,    32'h0,        0,  0,  0);
        vecs[16] = mk(0, 0, 2, 0,        0,        32'h3,    32'h0,    32'h0,    32'h0,        0,  0,  1);
        vecs[17] = mk(0, 1, 1, 32'h2,    0,        0,        32'h0,    32'h4,    32'h1000_0000, 1, 1,  1);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wp, vecs[i].ps, vecs[i].br, vecs[i].jt, vecs[i].rt);
            checkOutput($sformatf("v%0d.IF_pc", i),        IF_pc,              vecs[i].expPc);
            checkOutput($sformatf("v%0d.imem_addr", i),    imem_addr,          vecs[i].expPc);
            checkOutput($sformatf("v%0d.ID_pc_plus_4", i), ID_pc_plus_4,       vecs[i].expPp4);
            checkOutput($sformatf("v%0d.inst_stored", i),  inst_stored,        vecs[i].expInst);
            checkOutput($sformatf("v%0d.misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].expErr});
            checkOutput($sformatf("v%0d.cnt_fetch", i),    {28'b0, cnt_fetch}, {28'b0, vecs[i].expCf});
            checkOutput($sformatf("v%0d.cnt_stall", i),    {28'b0, cnt_stall}, {28'b0, vecs[i].expCs});
        end

        // Fetch counter saturation over 20 sequential advances.
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkOutput($sformatf("sat.cnt_fetch%0d", i), {28'b0, cnt_fetch}, (i < 15) ? i : 15);
        end
        checkOutput("sat.IF_pc", IF_pc, 32'd80);

        // Stall counter saturation; PC must stay frozen throughout.
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, 1, 32'h200, 0, 0);
            checkOutput($sformatf("sat.cnt_stall%0d", i), {28'b0, cnt_stall}, (i < 15) ? i : 15);
        end
        checkOutput("sat.pc_frozen", IF_pc, 32'd80);
        checkOutput("sat.cnt_fetch_held", {28'b0, cnt_fetch}, 32'd15);

        // PC wrap from the top of the address space.
        applyStimulus(0, 1, 3, 0, 32'hFFFF_FFFC, 0);
        checkOutput("wrap.IF_pc_top", IF_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("wrap.IF_pc", IF_pc, 32'h0000_0000);
        checkOutput("wrap.ID_pc_plus_4", ID_pc_plus_4, 32'h0000_0000);
        checkOutput("wrap.inst_stored", inst_stored, 32'h4FFF_FFFF);
        checkOutput("wrap.misalign_err", {31'b0, misalign_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
